// File: rtl/id_hazard_scoreboard.sv
// ID-stage RAW hazard scoreboard: per-register write-back countdowns drive stall, bubble and flush controls.
// Controls are combinational from ID inputs and counter state; counters and the stall counter update on i_clk.
module id_hazard_scoreboard #(
   parameter int P_WB_DIST = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_insnvld_ID,
   input  logic [4:0]  i_rs1_addr_ID,
   input  logic [4:0]  i_rs2_addr_ID,
   input  logic        i_rs1_used_ID,
   input  logic        i_rs2_used_ID,
   input  logic [4:0]  i_rd_addr_ID,
   input  logic        i_rdwren_ID,
   input  logic        i_br_taken_EX,
   output logic        o_stall_pc,
   output logic        o_stall_if_id,
   output logic        o_flush_if_id,
   output logic        o_bubble_id_ex,
   output logic [31:0] o_pending,
   output logic [31:0] o_stall_cnt
);

   localparam logic [1:0] LOAD_VAL = 2'(P_WB_DIST);

   // x0 has no counter, so the array starts at register 1.
   logic [31:1][1:0] cnt;
   logic [31:0]      pending;
   logic             rs1_busy;
   logic             rs2_busy;
   logic             hazard;
   logic             issue;
   logic             load;
   logic             hazard_stall;
   logic [31:0]      stall_cnt;

   always_comb begin
      pending = '0;
      for (int r = 1; r < 32; r++) begin
         pending[r] = (cnt[r] != 2'd0);
      end
   end

   assign rs1_busy = i_rs1_used_ID && (i_rs1_addr_ID != 5'd0) && pending[i_rs1_addr_ID];
   assign rs2_busy = i_rs2_used_ID && (i_rs2_addr_ID != 5'd0) && pending[i_rs2_addr_ID];
   assign hazard   = i_insnvld_ID && (rs1_busy || rs2_busy);

   assign issue        = i_insnvld_ID && !hazard && !i_br_taken_EX;
   assign load         = issue && i_rdwren_ID && (i_rd_addr_ID != 5'd0);
   assign hazard_stall = hazard && !i_br_taken_EX;

   // A redirect kills the ID instruction, so it overrides any hazard stall.
   always_comb begin
      o_stall_pc     = 1'b0;
      o_stall_if_id  = 1'b0;
      o_flush_if_id  = 1'b0;
      o_bubble_id_ex = 1'b0;
      if (i_br_taken_EX) begin
         o_flush_if_id  = 1'b1;
         o_bubble_id_ex = 1'b1;
      end else if (hazard) begin
         o_stall_pc     = 1'b1;
         o_stall_if_id  = 1'b1;
         o_bubble_id_ex = 1'b1;
      end
   end

   // A new writer reloads its counter even if an older write to rd is still in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            if (load && (i_rd_addr_ID == 5'(r))) begin
               cnt[r] <= LOAD_VAL;
            end else if (cnt[r] != 2'd0) begin
               cnt[r] <= cnt[r] - 2'd1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt <= '0;
      end else if (hazard_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign o_pending   = pending;
   assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: directed hazard scenarios plus randomized traffic against a write-back-time model.
module tb_id_hazard_scoreboard;

   localparam int P = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        insn_vld = 1'b0;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic        rs1_used = 1'b0;
   logic        rs2_used = 1'b0;
   logic [4:0]  rd = '0;
   logic        rdwren = 1'b0;
   logic        br = 1'b0;
   logic        o_stall_pc;
   logic        o_stall_if_id;
   logic        o_flush_if_id;
   logic        o_bubble_id_ex;
   logic [31:0] o_pending;
   logic [31:0] o_stall_cnt;

   id_hazard_scoreboard #(.P_WB_DIST(P)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_insnvld_ID   (insn_vld),
      .i_rs1_addr_ID  (rs1),
      .i_rs2_addr_ID  (rs2),
      .i_rs1_used_ID  (rs1_used),
      .i_rs2_used_ID  (rs2_used),
      .i_rd_addr_ID   (rd),
      .i_rdwren_ID    (rdwren),
      .i_br_taken_EX  (br),
      .o_stall_pc     (o_stall_pc),
      .o_stall_if_id  (o_stall_if_id),
      .o_flush_if_id  (o_flush_if_id),
      .o_bubble_id_ex (o_bubble_id_ex),
      .o_pending      (o_pending),
      .o_stall_cnt    (o_stall_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Model: each register remembers the edge number at which its newest writer reaches WB.
   int unsigned edges = 0;
   int unsigned wb_edge [32];
   logic [31:0] m_stall = '0;
   bit          m_h_upd;
   bit          m_h_chk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_busy(input logic used, input logic [4:0] a);
      return used && (a != 5'd0) && (wb_edge[a] > edges);
   endfunction

   function automatic bit m_hazard();
      return insn_vld && (m_busy(rs1_used, rs1) || m_busy(rs2_used, rs2));
   endfunction

   function automatic logic [31:0] m_pending();
      logic [31:0] p = '0;
      for (int r = 1; r < 32; r++) p[r] = (wb_edge[r] > edges);
      return p;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edges = 0;
         for (int r = 0; r < 32; r++) wb_edge[r] = 0;
         m_stall = '0;
      end else begin
         m_h_upd = m_hazard();
         if (!br && m_h_upd && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         edges++;
         if (insn_vld && !m_h_upd && !br && rdwren && rd != 5'd0) wb_edge[rd] = edges + P;
      end
   end

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         m_h_chk = m_hazard();
         check("stall_pc",  {31'd0, o_stall_pc},     {31'd0, !br && m_h_chk});
         check("stall_ifid", {31'd0, o_stall_if_id}, {31'd0, !br && m_h_chk});
         check("flush_ifid", {31'd0, o_flush_if_id}, {31'd0, br});
         check("bubble",    {31'd0, o_bubble_id_ex}, {31'd0, br || m_h_chk});
         check("pending",   o_pending, m_pending());
         check("stall_cnt", o_stall_cnt, m_stall);
      end
   end

   task automatic drive(input logic v, input logic [4:0] a1, input logic u1,
                        input logic [4:0] a2, input logic u2,
                        input logic [4:0] d, input logic w, input logic b);
      insn_vld = v; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
      rd = d; rdwren = w; br = b;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] d);
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, d, 1'b1, 1'b0);
      tick();
   endtask

   task automatic nop_insn();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
   endtask

   // Holds the current ID inputs until the instruction issues; bounded so a stuck stall is reported.
   task automatic count_stalls(input string name, input int exp);
      int  n = 0;
      bit  done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         #1;
         if (o_stall_pc) n++;
         else done = 1'b1;
         tick();
      end
      if (!done) $display("FAIL %s_timeout: still stalled after %0d cycles, required %0d", name, n, exp);
      check(name, n, exp);
   endtask

   task automatic settle();
      idle();
      repeat (4) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("rst_pending", o_pending, 32'd0);
      check("rst_stall_cnt", o_stall_cnt, 32'd0);
      check("rst_stall_pc", {31'd0, o_stall_pc}, 32'd0);
      check("rst_bubble", {31'd0, o_bubble_id_ex}, 32'd0);
      chk_en = 1'b1;
      tick();

      // Back-to-back RAW on x5
      write_reg(5'd5);
      check("b2b_pending5", {31'd0, o_pending[5]}, 32'd1);
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      count_stalls("b2b_stalls", 2);
      check("b2b_stall_cnt", o_stall_cnt, 32'd2);
      settle();

      // Distance 2 and distance 3 on x7
      write_reg(5'd7);
      nop_insn();
      drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
      count_stalls("dist2_stalls", 1);
      settle();
      write_reg(5'd7);
      nop_insn();
      nop_insn();
      drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
      count_stalls("dist3_stalls", 0);
      check("dist_stall_cnt", o_stall_cnt, 32'd3);
      settle();

      // x0 never tracked
      write_reg(5'd0);
      check("x0_pending", o_pending, 32'd0);
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
      count_stalls("x0_stalls", 0);
      settle();

      // Redirect while stalled on x5
      write_reg(5'd5);
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1 check("redir_pre_stall", {31'd0, o_stall_pc}, 32'd1);
      tick();
      check("redir_cnt_after_stall", o_stall_cnt, 32'd4);
      check("redir_pending5_mid", {31'd0, o_pending[5]}, 32'd1);
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      #1;
      check("redir_flush", {31'd0, o_flush_if_id}, 32'd1);
      check("redir_bubble", {31'd0, o_bubble_id_ex}, 32'd1);
      check("redir_stall_pc", {31'd0, o_stall_pc}, 32'd0);
      check("redir_stall_ifid", {31'd0, o_stall_if_id}, 32'd0);
      tick();
      check("redir_cnt_hold", o_stall_cnt, 32'd4);
      check("redir_pending5_end", {31'd0, o_pending[5]}, 32'd0);
      settle();

      // Write-after-write reload on x9
      write_reg(5'd9);
      write_reg(5'd9);
      check("waw_pending9", {31'd0, o_pending[9]}, 32'd1);
      drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      count_stalls("waw_stalls", 2);
      check("waw_stall_cnt", o_stall_cnt, 32'd6);
      settle();

      // Asynchronous reset in the middle of a stall
      write_reg(5'd5);
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      #1 rst_n = 1'b0;
      #1;
      check("arst_pending", o_pending, 32'd0);
      check("arst_stall_cnt", o_stall_cnt, 32'd0);
      check("arst_stall_pc", {31'd0, o_stall_pc}, 32'd0);
      #1 rst_n = 1'b1;
      count_stalls("arst_reader_stalls", 0);
      settle();

      // Randomized traffic over a small register window to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0,
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7) == 0);
         tick();
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_hazard_scoreboard.md
ID_HAZARD_SCOREBOARD -- requirements
Module: id_hazard_scoreboard

Interface
REQ-001 SHALL have parameter P_WB_DIST, default 2, meaning the number of clock edges from an instruction's ID->EX issue until it reaches WB (legal range 1..3).
REQ-002 SHALL have i_clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have i_insnvld_ID  input  1  the ID stage holds a valid instruction.
REQ-005 SHALL have i_rs1_addr_ID / i_rs2_addr_ID  input  5 each  source register addresses.
REQ-006 SHALL have i_rs1_used_ID / i_rs2_used_ID  input  1 each  the instruction reads that source.
REQ-007 SHALL have i_rd_addr_ID  input  5  destination register address.
REQ-008 SHALL have i_rdwren_ID  input  1  the instruction writes rd.
REQ-009 SHALL have i_br_taken_EX  input  1  a redirect (taken branch or jump) resolved in EX this cycle.
REQ-010 SHALL have o_stall_pc  output  1  hold the PC.
REQ-011 SHALL have o_stall_if_id  output  1  hold the IF/ID register.
REQ-012 SHALL have o_flush_if_id  output  1  load a NOP into the IF/ID register.
REQ-013 SHALL have o_bubble_id_ex  output  1  drives the flush input of the ID/EX register.
REQ-014 SHALL have o_pending  output  32  bit r set when register r has a write in flight; bit 0 is always 0.
REQ-015 SHALL have o_stall_cnt  output  32  saturating count of hazard-stall cycles.

Function
REQ-016 SHALL keep one 2-bit countdown cnt[r] for each of r = 1..31; o_pending[r] = (cnt[r] != 0).
REQ-017 SHALL treat the register file as write-through: a consumer in ID may proceed in the same cycle its producer is in WB.
REQ-018 SHALL compute hazard, combinationally, as i_insnvld_ID & ((i_rs1_used_ID & rs1 != 0 & cnt[rs1] != 0) | (i_rs2_used_ID & rs2 != 0 & cnt[rs2] != 0)).
REQ-019 SHALL give priority to redirect: when i_br_taken_EX = 1, o_flush_if_id = 1, o_bubble_id_ex = 1, and o_stall_pc = o_stall_if_id = 0, whatever the value of hazard.
REQ-020 SHALL, when there is no redirect and hazard = 1, assert o_stall_pc = o_stall_if_id = o_bubble_id_ex = 1 and o_flush_if_id = 0.
REQ-021 SHALL otherwise drive all four control outputs to 0.
REQ-022 SHALL define issue as i_insnvld_ID & ~hazard & ~i_br_taken_EX.
REQ-023 SHALL, on a clock edge where issue = 1 and i_rdwren_ID = 1 and rd != 0, load cnt[rd] with P_WB_DIST.
REQ-024 SHALL, on every edge, decrement by 1 each other cnt[r] that is nonzero; a cnt[r] at 0 stays 0.
REQ-025 SHALL give the load precedence over the decrement when a decrement and a new issue target the same register on the same edge (newest writer wins).
REQ-026 SHALL never allocate a counter for x0; writes to x0 and source reads of x0 never cause a stall.
REQ-027 SHALL produce no hazard for an invalid ID slot (i_insnvld_ID = 0), and such a slot issues nothing.
REQ-028 SHALL leave counters for already-issued (older) instructions untouched on a redirect; they keep counting down.
REQ-029 SHALL increment o_stall_cnt by 1 on each edge where REQ-020 applies, saturating at 32'hFFFF_FFFF with no wrap.
REQ-030 SHALL keep stall duration at or below P_WB_DIST cycles per producer, so there is no deadlock.
REQ-031 SHALL have zero-cycle latency for control outputs (combinational from inputs and state) and one-cycle latency for o_pending.

Reset
REQ-032 SHALL, while i_rst_n = 0, asynchronously clear every cnt[r] and o_stall_cnt to 0; o_pending = 0 and all control outputs = 0 while the ID inputs are idle.
REQ-033 SHALL, when reset is asserted mid-stall, discard all pending state, and the first instruction after reset SHALL issue without a stall.

Verification
REQ-034 SHALL cover back-to-back RAW: issue "add x5" and next ID reads x5 with P_WB_DIST = 2 -> exactly 2 stall cycles (bubble, PC and IF/ID held), issue on the 3rd cycle, o_stall_cnt = 2.
REQ-035 SHALL cover distance-2 RAW: one independent instruction between producer and consumer of x7 -> exactly 1 stall cycle; distance 3 -> 0 stalls.
REQ-036 SHALL cover x0: producer writes x0 and consumer reads x0 -> no stall, o_pending = 0.
REQ-037 SHALL cover redirect during a stall: consumer stalled on x5 and i_br_taken_EX = 1 -> o_flush_if_id = 1, o_bubble_id_ex = 1, o_stall_pc = 0, o_stall_cnt unchanged, o_pending[5] still decrements to 0.
REQ-038 SHALL cover a write-after-write re-load: issue write x9, then another write x9 on the next cycle -> cnt[9] reloads to 2, and a reader of x9 stalls 2 cycles after the second issue.
REQ-039 SHALL cover async reset: assert i_rst_n low mid-stall, between clock edges -> o_pending = 0 and o_stall_cnt = 0 immediately; after release, a reader of the previously pending register issues with no stall.
